// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-and-add-3).
//
// Converts one bit per clock. A start accepted while idle latches bin_in,
// then BIN_W shift cycles and one load cycle later bcd_out and overflow are
// updated together and done pulses for one cycle. Values above
// 10^DIGITS-1 are shown as all-blank digits (4'hF) with overflow set.
//
// Optional build macro: BIN2BCD_LEAD_BLANK_EN
//   When defined, leading zero digits (never digit 0) are replaced by the
//   blank code 4'hF at load time.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     conversion request, sampled while idle
//   bin_in    binary value, latched on the accepted start
//   busy      high while a conversion is in progress
//   done      one-cycle pulse when bcd_out has just been updated
//   overflow  last converted value exceeded 10^DIGITS-1
//   bcd_out   packed BCD digits, digit 0 at bits [3:0]

module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  // Largest representable value, computed wide so the comparison against
  // bin_in never truncates either side.
  function automatic logic [63:0] max_value(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(DIGITS);

  state_t            state_q, state_d;
  logic [BIN_W-1:0]  bin_q;
  logic [SW-1:0]     scr_q;
  logic [SW-1:0]     scr_adj;
  logic [SW-1:0]     load_val;
  logic [CW-1:0]     cnt_q;
  logic              ovf_pend_q;
  logic              ovf_now;
  logic              last_shift;
  logic [SW-1:0]     bcd_q;
  logic              ovf_q;
  logic              done_q;

  assign ovf_now    = 64'(bin_in) > MAX_VAL;
  assign last_shift = (cnt_q == CW'(BIN_W - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    overflow = ovf_q;
    bcd_out  = bcd_q;
  end

  // Add-3 correction: each nibble >= 5 gets +3 before the shift so that it
  // carries correctly into the next digit once doubled.
  always_comb begin
    scr_adj = scr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scr_q[4*d +: 4] >= 4'd5) scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
    end
  end

  // Value presented at load: optional leading-zero blanking, overridden by
  // the all-blank pattern on overflow.
  always_comb begin
`ifdef BIN2BCD_LEAD_BLANK_EN
    logic leading;
    leading  = 1'b1;
    load_val = scr_q;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (leading && (scr_q[4*d +: 4] == 4'd0)) load_val[4*d +: 4] = 4'hF;
      else                                      leading = 1'b0;
    end
`else
    load_val = scr_q;
`endif
    if (ovf_pend_q) load_val = '1;
  end

  // Datapath registers. All are plain flops, so all are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == LOAD);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            bin_q      <= bin_in;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= ovf_now;
          end
        end
        SHIFT: begin
          // Bits leaving the top digit are dropped; that only happens on
          // overflow, where the result is masked anyway.
          scr_q <= {scr_adj[SW-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
        end
        LOAD: begin
          bcd_q <= load_val;
          ovf_q <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed vectors, expected results queued at
// stimulus time and compared by an independent monitor on each done pulse.

module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd_out;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out)
  );

`ifdef BIN2BCD_LEAD_BLANK_EN
  localparam logic [15:0] E7   = 16'hFFF7;
  localparam logic [15:0] E0   = 16'hFFF0;
  localparam logic [15:0] E42  = 16'hFF42;
  localparam logic [15:0] E999 = 16'hF999;
  localparam logic [15:0] E321 = 16'hF321;
`else
  localparam logic [15:0] E7   = 16'h0007;
  localparam logic [15:0] E0   = 16'h0000;
  localparam logic [15:0] E42  = 16'h0042;
  localparam logic [15:0] E999 = 16'h0999;
  localparam logic [15:0] E321 = 16'h0321;
`endif

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(e.bcd));
        check("overflow", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  logic [15:0] held;

  // Drive a start on the current negedge; optionally queue the expectation.
  task automatic issue(input logic [13:0] v, input bit push,
                       input logic [15:0] eb, input logic eo);
    exp_t e;
    bin_in = v;
    start  = 1'b1;
    held   = bcd_out;
    if (push) begin
      e.bcd = eb;
      e.ovf = eo;
      exp_q.push_back(e);
    end
  endtask

  // Wait (bounded) for done; count busy cycles and watch bcd_out stability.
  task automatic wait_done(output int bc);
    bit seen;
    bit changed;
    seen    = 1'b0;
    changed = 1'b0;
    bc      = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      if (bcd_out !== held) changed = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("hold_during_conv", 32'(changed), 32'd0);
  endtask

  task automatic convert(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    int bc;
    issue(v, 1'b1, eb, eo);
    wait_done(bc);
    check("busy_cycles", 32'(bc), 32'd15);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int bc;
    int dc0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    held   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    convert(14'd1234,  16'h1234, 1'b0);
    convert(14'd9999,  16'h9999, 1'b0);
    convert(14'd10000, 16'hFFFF, 1'b1);
    convert(14'd7,     E7,       1'b0);
    convert(14'd0,     E0,       1'b0);
    check("digit0_kept", 32'(bcd_out[3:0]), 32'd0);

    // Start while busy is ignored; bin_in changes after latch are ignored.
    dc0 = done_cnt;
    issue(14'd42, 1'b1, E42, 1'b0);
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    bin_in = 14'd999;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 14'd123;
    wait_done(bc);
    #1;
    // Start in the done cycle is accepted.
    issue(14'd999, 1'b1, E999, 1'b0);
    wait_done(bc);
    check("busy_cycles_b2b", 32'(bc), 32'd15);
    #1;
    check("done_count_b2b", 32'(done_cnt - dc0), 32'd2);

    // Reset mid-conversion aborts with no done pulse.
    @(negedge clk);
    dc0 = done_cnt;
    issue(14'd5000, 1'b0, 16'h0, 1'b0);
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - dc0), 32'd0);

    convert(14'd321, E321, 1'b0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
